// File: rtl/print_bus_pkg.sv
// Shared types and constants for the print-path bus initiator.
package print_bus_pkg;

  localparam int unsigned ADDR_DATA_W = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned BURST_W     = 8;
  localparam int unsigned BEAT_W      = 9;

  localparam logic [BE_W-1:0] BYTE_EN_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEGIN,
    ST_DATA,
    ST_END
  } state_e;

  typedef struct packed {
    logic [ADDR_DATA_W-1:0] addr_data;
    logic [BE_W-1:0]        byte_en;
    logic [BURST_W-1:0]     burst_size;
    logic                   request;
    logic                   beg_txn;
    logic                   end_txn;
    logic                   valid;
  } bus_out_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO with count; peek_o exposes the word after the head.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [WIDTH-1:0]         peek_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_acc, pop_acc;

  // Full is judged on the pre-pop count, so a push while full is refused.
  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign peek_o  = mem_q[rd_ptr_q + PTR_W'(1)];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/print_bus_master.sv
// Drains a local word FIFO into write bursts at a fixed print-peripheral address.
module print_bus_master
  import print_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h6000_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [ADDR_DATA_W-1:0] pushData_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [15:0]            droppedCount_o,
  output logic [15:0]            errorCount_o,
  output logic                   bus_request_o,
  input  logic                   bus_grant_i,
  output logic [ADDR_DATA_W-1:0] bus_addrData_o,
  output logic [BE_W-1:0]        bus_byteEnables_o,
  output logic [BURST_W-1:0]     bus_burstSize_o,
  output logic                   bus_readNWrite_o,
  output logic                   bus_beginTransaction_o,
  output logic                   bus_endTransaction_o,
  output logic                   bus_dataValid_o,
  input  logic                   bus_busy_i,
  input  logic                   bus_error_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      len_q, len_d, beat_q, beat_d;
  bus_out_t               bus_q, bus_d;
  logic [15:0]            drop_q, err_q;
  logic                   pop, err_inc;
  logic [ADDR_DATA_W-1:0] fifo_head, fifo_next;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  sync_word_fifo #(
    .WIDTH(ADDR_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_i),
    .pop_i  (pop),
    .data_i (pushData_i),
    .data_o (fifo_head),
    .peek_o (fifo_next),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Next state, then bus outputs decoded from the next state so they leave on flops.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    err_inc = 1'b0;
    bus_d   = '0;

    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ: begin
        if (bus_grant_i) begin
          if (32'(fifo_count) > MAX_BURST) len_d = BEAT_W'(MAX_BURST);
          else                             len_d = BEAT_W'(fifo_count);
          state_d = ST_BEGIN;
        end
      end
      ST_BEGIN: begin
        beat_d = '0;
        if (bus_error_i) begin
          err_inc = 1'b1;
          state_d = ST_END;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_error_i) begin
          err_inc = 1'b1;
          state_d = ST_END;
        end else if (!bus_busy_i) begin
          pop    = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_d == len_q) state_d = ST_END;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_REQ: bus_d.request = 1'b1;
      ST_BEGIN: begin
        bus_d.request    = 1'b1;
        bus_d.beg_txn    = 1'b1;
        bus_d.addr_data  = BASE_ADDR;
        bus_d.byte_en    = BYTE_EN_ALL;
        bus_d.burst_size = BURST_W'(len_d - BEAT_W'(1));
      end
      ST_DATA: begin
        bus_d.request   = 1'b1;
        bus_d.valid     = 1'b1;
        bus_d.addr_data = pop ? fifo_next : fifo_head;
      end
      ST_END: begin
        bus_d.request = 1'b1;
        bus_d.end_txn = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      bus_q   <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      bus_q   <= bus_d;
      if (push_i && fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (err_inc && err_q != 16'hFFFF)              err_q  <= err_q + 16'd1;
    end
  end

  assign full_o                 = fifo_full;
  assign empty_o                = fifo_empty;
  assign droppedCount_o         = drop_q;
  assign errorCount_o           = err_q;
  assign bus_request_o          = bus_q.request;
  assign bus_addrData_o         = bus_q.addr_data;
  assign bus_byteEnables_o      = bus_q.byte_en;
  assign bus_burstSize_o        = bus_q.burst_size;
  assign bus_readNWrite_o       = 1'b0;
  assign bus_beginTransaction_o = bus_q.beg_txn;
  assign bus_endTransaction_o   = bus_q.end_txn;
  assign bus_dataValid_o        = bus_q.valid;

endmodule

// File: doc/print_bus_master.md
Name: print_bus_master

Overview:
- Bus initiator that drains a local word FIFO into write bursts on the shared multiplexed address/data bus.
- It targets a fixed print-peripheral base address and is the transmitting end of the print path.
- Sits between a core/testbench-side push interface and the bus arbiter plus slaves.
- Bus outputs are all-zero whenever the block does not own the bus, so they can be OR-combined with other initiators.

Parameters:
- BASE_ADDR, 32'h60000000, address driven in the begin cycle of every burst.
- FIFO_DEPTH, 16, word capacity of the local FIFO; power of 2, minimum 2.
- MAX_BURST, 8, maximum words per burst; range 1..256.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- push_i  in  1  write pushData_i into the FIFO this cycle
- pushData_i  in  32  word to print
- full_o  out  1  FIFO holds FIFO_DEPTH words
- empty_o  out  1  FIFO holds 0 words
- droppedCount_o  out  16  saturating count of pushes refused because the FIFO was full
- errorCount_o  out  16  saturating count of bursts aborted by bus_error_i
- bus_request_o  out  1  arbitration request
- bus_grant_i  in  1  arbitration grant
- bus_addrData_o  out  32  address in the begin cycle, data in data cycles, 0 otherwise
- bus_byteEnables_o  out  4  4'hF in the begin cycle, 0 otherwise
- bus_burstSize_o  out  8  burst length minus 1 in the begin cycle, 0 otherwise
- bus_readNWrite_o  out  1  always 0 (write only)
- bus_beginTransaction_o  out  1  begin-cycle strobe
- bus_endTransaction_o  out  1  end-cycle strobe
- bus_dataValid_o  out  1  data word present
- bus_busy_i  in  1  slave stall; the current beat is not accepted
- bus_error_i  in  1  slave/bus error; abort the burst

Behaviour:
- Reset: while rst_ni is low, all outputs are 0 except empty_o=1. FIFO is emptied, counters are 0, FSM is in IDLE. Reset takes effect immediately, including mid-burst.
- All bus outputs are driven from flops. There is no combinational path from any input to any output.

FIFO push side:
- A push is accepted when push_i=1 and full_o=0.
- full_o is evaluated before any same-cycle pop. A push while full is therefore dropped even if a pop happens in the same cycle; droppedCount_o increments by 1 and saturates at 16'hFFFF.
- Simultaneous push and pop when not full: count is unchanged and both take effect.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, REQ, BEGIN, DATA, END.
- IDLE: all bus outputs 0. If the FIFO is not empty, go to REQ.
- REQ: bus_request_o=1.
  - On the first edge with bus_grant_i=1, latch len = min(FIFO count, MAX_BURST) and go to BEGIN.
  - len is fixed for the whole burst; words pushed later wait for the next burst.
- BEGIN (exactly 1 cycle): bus_beginTransaction_o=1, bus_addrData_o=BASE_ADDR, bus_burstSize_o=len-1, bus_byteEnables_o=4'hF. Next state is DATA.
- DATA: bus_dataValid_o=1 and bus_addrData_o = FIFO head.
  - A beat is accepted in a cycle where bus_busy_i=0. On acceptance the word is popped and the beat counter increments.
  - If bus_busy_i=1, the same word is held.
  - After beat len is accepted, go to END; there is no dead cycle between beats.
- END (exactly 1 cycle): bus_endTransaction_o=1, all other bus outputs 0. Next state is IDLE, so back-to-back bursts are separated by IDLE then REQ.
- bus_request_o is 1 in REQ, BEGIN, DATA and END, and 0 otherwise.
- Error handling: bus_error_i=1 sampled in BEGIN or DATA causes:
  - no pop that cycle;
  - errorCount_o increments (saturating);
  - next state is END.
  - Unsent words remain in the FIFO and are retried in a later burst.
- Loss of bus_grant_i after REQ is ignored; the owner releases only via END.
- Beat counter width is 9 bits so that MAX_BURST=256 is representable.

Decomposition:
- Shared package print_bus_pkg holds:
  - the FSM state enum;
  - bus width constants (ADDR_DATA_W=32, BE_W=4, BURST_W=8);
  - BYTE_EN_ALL=4'hF.
- Sub-module sync_word_fifo (parameters WIDTH, DEPTH; ports push, pop, data in/out, full, empty, count). It is reusable by other initiators.

Test Plan:
- Push 3 words (A1,A2,A3), grant 2 cycles after request:
  - begin cycle shows addr 32'h60000000 and burstSize 2;
  - then 3 consecutive dataValid beats A1,A2,A3;
  - then 1 end cycle;
  - request drops; empty_o=1.
- Push 11 words with MAX_BURST=8: two bursts with burstSize 7 then 2, separated by IDLE and REQ; data order is preserved.
- During DATA, hold bus_busy_i high for 3 cycles on beat 2: the beat-2 word is held on the bus for 4 cycles and no word is skipped or duplicated.
- Assert bus_error_i on beat 2 of a 4-word burst:
  - an END cycle follows;
  - errorCount_o=1;
  - words 2–4 are resent in the next burst with burstSize 2.
- Push 17 words with no grant: full_o=1 after 16, and droppedCount_o=1.
- Deassert rst_ni mid-DATA: all bus outputs are 0 in the same cycle, empty_o=1, and no begin strobe appears until a new push.
